// File: rtl/axis_i2c_frontend.sv
// AXI-Stream to I2C master command front end: turns {addr, payload...} packets
// into FIFO writes and pumps FIFO reads whenever the master FSM is idle.
module axis_i2c_frontend #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic              fsm_ready,
  output logic              fifo_rd_en,
  output logic              err_empty_pkt,
  output logic [CNT_W-1:0]  pkt_cnt
);

  typedef enum logic {S_ADDR, S_DATA} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr_reg;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr_en;
  logic                r_rd_en;
  logic                r_err;
  logic [CNT_W-1:0]    r_pkt_cnt;
  logic                w_tready;
  logic                w_accept;

  // Gating on r_wr_en leaves a gap after every write so fifo_full is current
  // before the next payload beat is taken.
  always_comb begin
    w_tready = 1'b0;
    if (arst) begin
      if (r_state == S_ADDR) w_tready = 1'b1;
      else                   w_tready = !fifo_full && !r_wr_en;
    end
  end

  assign w_accept = s_axis_tvalid && w_tready;

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_state    <= S_ADDR;
      r_addr_reg <= '0;
      r_data     <= '0;
      r_addr     <= '0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_err      <= 1'b0;
      r_pkt_cnt  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_err   <= 1'b0;
      r_rd_en <= fsm_ready && !fifo_empty && !r_rd_en;
      if (w_accept) begin
        case (r_state)
          S_ADDR: begin
            r_addr_reg <= s_axis_tdata[ADDR_W-1:0];
            if (s_axis_tlast) r_err   <= 1'b1;
            else              r_state <= S_DATA;
          end
          S_DATA: begin
            r_data  <= s_axis_tdata;
            r_addr  <= r_addr_reg;
            r_wr_en <= 1'b1;
            if (s_axis_tlast) begin
              r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
              r_state   <= S_ADDR;
            end
          end
          default: r_state <= S_ADDR;
        endcase
      end
    end
  end

  assign s_axis_tready = w_tready;
  assign data          = r_data;
  assign addr          = r_addr;
  assign fifo_wr_en    = r_wr_en;
  assign fifo_rd_en    = r_rd_en;
  assign err_empty_pkt = r_err;
  assign pkt_cnt       = r_pkt_cnt;

endmodule

// File: tb/tb_axis_i2c_frontend.sv
// Directed bench for axis_i2c_frontend: packets, backpressure, empty packets,
// mid-packet reset, read pump and counter wrap (second instance, CNT_W = 2).
module tb_axis_i2c_frontend;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic [7:0] tdata = '0;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  logic       fifoFull = 1'b0;
  logic       fifoEmpty = 1'b1;
  logic       fsmReady = 1'b0;

  logic        tready, wrEn, rdEn, errPkt;
  logic [7:0]  dataOut;
  logic [6:0]  addrOut;
  logic [15:0] pktCnt;

  logic        trdyW, wrEnW, rdEnW, errW;
  logic [7:0]  dataW;
  logic [6:0]  addrW;
  logic [1:0]  pktCntW;

  int testsRun = 0;
  int failCount = 0;
  int backToBack = 0;
  int wrWhileFull = 0;
  logic prevWr = 1'b0;
  logic prevFull = 1'b0;
  logic [14:0] wrQ[$];

  always #5 clk = ~clk;

  axis_i2c_frontend dut (
    .clk(clk), .arst(arst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(tready), .data(dataOut), .addr(addrOut),
    .fifo_wr_en(wrEn), .fifo_full(fifoFull), .fifo_empty(fifoEmpty),
    .fsm_ready(fsmReady), .fifo_rd_en(rdEn), .err_empty_pkt(errPkt), .pkt_cnt(pktCnt)
  );

  axis_i2c_frontend #(.CNT_W(2)) dutWrap (
    .clk(clk), .arst(arst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(trdyW), .data(dataW), .addr(addrW),
    .fifo_wr_en(wrEnW), .fifo_full(fifoFull), .fifo_empty(fifoEmpty),
    .fsm_ready(fsmReady), .fifo_rd_en(rdEnW), .err_empty_pkt(errW), .pkt_cnt(pktCntW)
  );

  // Write monitor: records every strobe and flags adjacent or full-time writes.
  always @(negedge clk) begin
    if (wrEn) begin
      wrQ.push_back({addrOut, dataOut});
      if (prevWr) backToBack++;
      if (fifoFull && prevFull) wrWhileFull++;
    end
    prevWr   = wrEn;
    prevFull = fifoFull;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic last);
    bit done = 0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (tready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (!done) checkOutput("beat_timeout", 0, 1);
  endtask

  task automatic expectWrite(input string tag, input logic [6:0] a, input logic [7:0] d);
    logic [14:0] w;
    if (wrQ.size() == 0) begin
      checkOutput({tag, "_present"}, 0, 1);
    end else begin
      w = wrQ.pop_front();
      checkOutput({tag, "_addr"}, 32'(w[14:8]), 32'(a));
      checkOutput({tag, "_data"}, 32'(w[7:0]), 32'(d));
    end
  endtask

  task automatic doReset(input int n);
    arst = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tready", 32'(tready), 0);
    checkOutput("rst_outs", {wrEn, rdEn, errPkt, dataOut, addrOut}, 0);
    checkOutput("rst_cnt", 32'(pktCnt), 0);
    @(posedge clk);
    #1;
    arst = 1'b1;
  endtask

  initial begin
    logic [1:0] wrapExp [5];
    wrapExp[0] = 2'd1; wrapExp[1] = 2'd2; wrapExp[2] = 2'd3; wrapExp[3] = 2'd0; wrapExp[4] = 2'd1;

    doReset(2);

    // Basic packet
    applyStimulus(8'h50, 0);
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h3C, 1);
    waitCycles(3);
    expectWrite("basic0", 7'h50, 8'hA5);
    expectWrite("basic1", 7'h50, 8'h3C);
    checkOutput("basic_cnt", 32'(pktCnt), 1);

    // Backpressure on the second payload beat
    applyStimulus(8'h60, 0);
    applyStimulus(8'h11, 0);
    waitCycles(1);
    fifoFull = 1'b1;
    tvalid = 1'b1; tdata = 8'h22; tlast = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_tready", 32'(tready), 0);
      checkOutput("bp_wr", 32'(wrEn), 0);
      @(posedge clk);
      #1;
    end
    fifoFull = 1'b0;
    applyStimulus(8'h22, 1);
    waitCycles(3);
    expectWrite("bp0", 7'h60, 8'h11);
    expectWrite("bp1", 7'h60, 8'h22);
    checkOutput("bp_extra", 32'(wrQ.size()), 0);
    checkOutput("bp_cnt", 32'(pktCnt), 2);

    // Empty packet, then a normal one
    applyStimulus(8'h7F, 1);
    @(negedge clk);
    checkOutput("empty_err", 32'(errPkt), 1);
    @(negedge clk);
    checkOutput("empty_err_off", 32'(errPkt), 0);
    checkOutput("empty_nowr", 32'(wrQ.size()), 0);
    @(posedge clk);
    #1;
    applyStimulus(8'h12, 0);
    applyStimulus(8'h99, 1);
    waitCycles(3);
    expectWrite("afterEmpty", 7'h12, 8'h99);
    checkOutput("empty_cnt", 32'(pktCnt), 3);

    // Reset mid-packet: the already-accepted 0x01 still writes, then state resets
    applyStimulus(8'h20, 0);
    applyStimulus(8'h01, 0);
    doReset(1);
    waitCycles(1);
    expectWrite("midRstOld", 7'h20, 8'h01);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h44, 1);
    waitCycles(3);
    expectWrite("midRstNew", 7'h33, 8'h44);
    checkOutput("midRst_cnt", 32'(pktCnt), 1);

    // Read pump
    fsmReady = 1'b1;
    fifoEmpty = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("pump_%0d", i), 32'(rdEn), 32'(i % 2));
      @(posedge clk);
      #1;
    end
    fifoEmpty = 1'b1;
    waitCycles(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("pump_empty", 32'(rdEn), 0);
    end
    @(posedge clk);
    #1;
    fifoEmpty = 1'b0;
    fsmReady = 1'b0;
    waitCycles(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("pump_notready", 32'(rdEn), 0);
    end
    @(posedge clk);
    #1;
    fifoEmpty = 1'b1;

    // Counter wrap on the CNT_W = 2 instance
    doReset(2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h40 + 8'(i), 0);
      applyStimulus(8'hC0 + 8'(i), 1);
      waitCycles(2);
      expectWrite($sformatf("wrap_wr%0d", i), 7'(8'h40 + 8'(i)), 8'hC0 + 8'(i));
      checkOutput($sformatf("wrap_cnt%0d", i), 32'(pktCntW), 32'(wrapExp[i]));
      checkOutput($sformatf("main_cnt%0d", i), 32'(pktCnt), 32'(i + 1));
    end

    checkOutput("gap_between_writes", 32'(backToBack), 0);
    checkOutput("no_write_while_full", 32'(wrWhileFull), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/axis_i2c_frontend.md
# axis_i2c_frontend

Upstream command front end for the I2C master. Accepts byte packets on an AXI-Stream slave port, turns each packet into {addr, data} writes into the master's command FIFO, and pumps FIFO reads whenever the master FSM is ready. The I2C master sees its `data`, `addr`, `fifo_wr_en` and `fifo_rd_en` inputs driven by this block instead of by software or a bench.

## Interface
- `ADDR_W`, 7, I2C slave address width
- `DATA_W`, 8, payload byte width; also the `s_axis_tdata` width
- `CNT_W`, 16, width of the completed-packet counter

- `clk`  in  1  single system clock; all logic on rising edge
- `arst`  in  1  reset; synchronous, active-low (0 = reset)
- `s_axis_tdata`  in  DATA_W  stream byte
- `s_axis_tvalid`  in  1  stream beat valid
- `s_axis_tlast`  in  1  last beat of packet
- `s_axis_tready`  out  1  beat accepted when `tvalid & tready`
- `data`  out  DATA_W  payload byte to master FIFO
- `addr`  out  ADDR_W  slave address to master FIFO
- `fifo_wr_en`  out  1  one-cycle write strobe to master FIFO
- `fifo_full`  in  1  master FIFO full
- `fifo_empty`  in  1  master FIFO empty
- `fsm_ready`  in  1  master FSM idle, can take a command
- `fifo_rd_en`  out  1  one-cycle read strobe to master FIFO
- `err_empty_pkt`  out  1  one-cycle pulse: packet had an address beat only
- `pkt_cnt`  out  CNT_W  count of completed packets

## Operation
- Packet format: beat 0 = address byte, `addr_reg <= tdata[ADDR_W-1:0]` (bit 7 ignored); beats 1..N = payload bytes, all sent to that address.
- FSM states: S_ADDR (reset state), S_DATA.
  - S_ADDR: `tready = 1`. On accepted beat, latch `addr_reg`. If `tlast = 0` go to S_DATA. If `tlast = 1`, pulse `err_empty_pkt` and stay in S_ADDR.
  - S_DATA: `tready = !fifo_full & !fifo_wr_en`. On accepted beat, register `data <= tdata` and `addr <= addr_reg`, and assert `fifo_wr_en` for the next cycle. If `tlast = 1`, increment `pkt_cnt` and go to S_ADDR.
- The `!fifo_wr_en` term in `tready` allows at most one write every two cycles. This ensures the FIFO's `full` flag reflects the previous write before another beat is accepted, so the FIFO can never be overrun.
- Read pump: `fifo_rd_en <= fsm_ready & !fifo_empty & !fifo_rd_en`. This gives a one-cycle pulse with at least one low cycle between pulses. The pump runs independently of the FSM.
- `pkt_cnt` wraps from 2^CNT_W−1 to 0 with no flag.
- Reset (`arst = 0` at a clock edge):
  - Registers: state = S_ADDR, `addr_reg = 0`, `data = 0`, `addr = 0`, `fifo_wr_en = 0`, `fifo_rd_en = 0`, `err_empty_pkt = 0`, `pkt_cnt = 0`.
  - `s_axis_tready` is forced to 0 while `arst = 0`.
  - Reset mid-packet discards the partial packet. The first beat after reset is treated as an address byte.

## Timing
- Beat accepted at edge k: `data`/`addr` valid and `fifo_wr_en = 1` during cycle k+1 only. `data`/`addr` hold their values until the next write.
- Payload throughput: 1 byte per 2 cycles maximum. An address beat costs 1 cycle.
- `err_empty_pkt` is high during cycle k+1 for an address-only beat accepted at edge k.
- `pkt_cnt` updates at the edge after the last beat is accepted.
- `fifo_rd_en` rises one cycle after `fsm_ready & !fifo_empty` is first seen high at an edge.
- `fifo_full` asserted in S_DATA: `tready` drops combinationally in the same cycle. An already-registered `fifo_wr_en` still completes.
- Simultaneous `fifo_wr_en` and `fifo_rd_en` are allowed; the FIFO handles concurrent read and write.

## Test plan
- Reset and basic packet:
  - Stimulus: hold `arst = 0` for 2 cycles and check all outputs are 0 and `tready = 0`. Then send packet {0x50, 0xA5, 0x3C (tlast)} with `fifo_full = 0`.
  - Required: two `fifo_wr_en` pulses, first with addr = 0x50, data = 0xA5, then with addr = 0x50, data = 0x3C, separated by ≥1 low cycle; `pkt_cnt = 1`.
- Backpressure:
  - Stimulus: hold `fifo_full = 1` during the second payload beat for 5 cycles, then release.
  - Required: `tready = 0` for those 5 cycles; no write strobe while full; the byte is written exactly once after release with the correct value.
- Empty packet:
  - Stimulus: single beat 0x7F with `tlast = 1`, then packet {0x12, 0x99 (tlast)}.
  - Required: one `err_empty_pkt` pulse and no write for the empty packet; then one write with addr = 0x12, data = 0x99; `pkt_cnt` increments only once.
- Reset mid-packet:
  - Stimulus: send 0x20, 0x01, then assert reset for 1 cycle, then send {0x33, 0x44 (tlast)}.
  - Required: the 0x20 packet is abandoned; the next write has addr = 0x33, data = 0x44.
- Read pump:
  - Stimulus: `fifo_empty = 0`, `fsm_ready = 1` for 6 cycles.
  - Required: `fifo_rd_en` pattern 0,1,0,1,0,1. With `fifo_empty = 1` or `fsm_ready = 0`, no pulses.
- Counter wrap:
  - Stimulus: CNT_W = 2, send 5 one-byte packets.
  - Required: `pkt_cnt` sequence 1,2,3,0,1.
